// File: rtl/axi_mmu_pkg.sv
// Shared types for the MMU write path: scheduler state encoding, queued
// write-command layout and default AXI field widths.
package axi_mmu_pkg;

  localparam int AXI_ID_W  = 4;
  localparam int AXI_LEN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_XLAT = 2'd1,
    ST_START     = 2'd2,
    ST_STREAM    = 2'd3
  } wburst_state_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]  id;
    logic [AXI_LEN_W-1:0] len;
  } wcmd_t;

endpackage

// File: rtl/axi_cmd_fifo.sv
// Single-clock command FIFO with a first-word-fall-through head, occupancy
// count and full/empty flags. DEPTH must be a power of two.
module axi_cmd_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   pop,
  output logic [DATA_W-1:0]      head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array is intentionally not reset; validity is defined
  // solely by the pointers and count, which keeps the array RAM-mappable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/axi_wburst_sched.sv
// Write-burst scheduler: queues AXI write-address bursts, starts the data
// channel once the head burst is translated, and checks beats against it.
module axi_wburst_sched
  import axi_mmu_pkg::*;
#(
  parameter int CMD_DEPTH = 8,
  parameter int LEN_W     = AXI_LEN_W,
  parameter int ID_W      = AXI_ID_W
) (
  input  logic                         tx_clk,
  input  logic                         txreset,
  input  logic [ID_W-1:0]              in_awid,
  input  logic [LEN_W-1:0]             in_awlen,
  input  logic                         in_awvalid,
  output logic                         out_awready,
  input  logic                         in_xlat_done,
  output logic                         out_start,
  input  logic                         in_wbeat,
  input  logic [ID_W-1:0]              in_wid,
  input  logic                         in_wlast,
  output logic                         out_busy,
  output logic [$clog2(CMD_DEPTH):0]   out_outstanding,
  output logic                         out_err_len,
  output logic                         out_err_id
);

  localparam int CNT_W = $clog2(CMD_DEPTH) + 1;

  wburst_state_t         state_q, state_d;
  logic [LEN_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  err_len_q, err_len_d;
  logic                  err_id_q, err_id_d;

  logic                  push, pop, burst_end;
  logic [ID_W+LEN_W-1:0] head;
  logic [ID_W-1:0]       head_id;
  logic [LEN_W-1:0]      head_len;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full, fifo_empty;

  // The active burst stays at the queue head until its last beat, so the
  // queue occupancy already counts queued plus active bursts.
  assign out_awready = ~fifo_full;
  assign push        = in_awvalid & ~fifo_full;

  axi_cmd_fifo #(
    .DEPTH  (CMD_DEPTH),
    .DATA_W (ID_W + LEN_W)
  ) u_cmd_fifo (
    .clk   (tx_clk),
    .rst   (txreset),
    .push  (push),
    .wdata ({in_awid, in_awlen}),
    .pop   (pop),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_id  = head[ID_W+LEN_W-1:LEN_W];
  assign head_len = head[LEN_W-1:0];

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    err_len_d  = err_len_q;
    err_id_d   = err_id_q;
    burst_end  = 1'b0;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_WAIT_XLAT;
      end
      ST_WAIT_XLAT: begin
        if (in_xlat_done) state_d = ST_START;
      end
      ST_START: begin
        beat_cnt_d = '0;
        state_d    = ST_STREAM;
      end
      ST_STREAM: begin
        if (in_wbeat) begin
          if (in_wid != head_id) err_id_d = 1'b1;
          if (in_wlast && (beat_cnt_q < head_len)) begin
            err_len_d = 1'b1;
            burst_end = 1'b1;
          end else if (beat_cnt_q == head_len) begin
            if (!in_wlast) err_len_d = 1'b1;
            burst_end = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
        if (burst_end) begin
          pop     = 1'b1;
          state_d = ((fifo_count > CNT_W'(1)) || push) ? ST_WAIT_XLAT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge tx_clk) begin
    if (txreset) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      err_len_q  <= 1'b0;
      err_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      err_len_q  <= err_len_d;
      err_id_q   <= err_id_d;
    end
  end

  // Gating with txreset keeps a START state from leaking a pulse in the reset cycle.
  assign out_start       = (state_q == ST_START) & ~txreset;
  assign out_busy        = (state_q != ST_IDLE) | ~fifo_empty;
  assign out_outstanding = fifo_count;
  assign out_err_len     = err_len_q;
  assign out_err_id      = err_id_q;

endmodule
